// File: rtl/ram_bus_master_if.sv
// User-side request/response and RAM strobe signals for ram_bus_master.
// The shared data bus is a plain inout on the master because it is tristated.
interface ram_bus_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
);
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);

    logic                  req;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic                  chip_select;

    modport master (
        input  req, req_write, req_addr, req_wdata,
        output ready, rd_valid, rd_data, address, write, chip_select
    );

    modport slave (
        output req, req_write, req_addr, req_wdata,
        input  ready, rd_valid, rd_data, address, write, chip_select
    );
endinterface

// File: rtl/ram_bus_master.sv
// Sequences single SRAM reads/writes through SETUP, ACCESS (WAIT_CYCLES clocks), RECOVER.
// Transaction is WAIT_CYCLES+3 clocks; requests are taken only in IDLE, never queued.
module ram_bus_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_bus_master_if.master      bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
    localparam int CNT_WIDTH  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  accept;
    logic                  capture;
    logic                  drive;
    logic                  ready_c;
    logic                  cs_c;
    logic                  write_c;
    logic                  rd_valid_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        ready_c    = 1'b0;
        cs_c       = 1'b0;
        write_c    = 1'b0;
        rd_valid_c = 1'b0;
        drive      = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_c      = 1'b1;
                drive     = lat_write;
                cnt_nxt   = CNT_LOAD;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                cs_c    = 1'b1;
                write_c = lat_write;
                drive   = lat_write;
                if (cnt == '0) begin
                    capture   = ~lat_write;
                    state_nxt = RECOVER;
                end else begin
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                end
            end
            RECOVER: begin
                // Write data stays on the bus one extra clock as hold time.
                drive      = lat_write;
                rd_valid_c = ~lat_write;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (capture) begin
                rd_data_q <= data;
            end
        end
    end

    assign data            = drive ? lat_wdata : {DATA_WIDTH{1'bz}};
    assign bus.ready       = ready_c;
    assign bus.rd_valid    = rd_valid_c;
    assign bus.rd_data     = rd_data_q;
    assign bus.address     = lat_addr;
    assign bus.write       = write_c;
    assign bus.chip_select = cs_c;
endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench: two masters (8-bit/256-word/W=2 and 16-bit/200-word/W=1), each on its own RAM model.
`timescale 1ns/1ps
module tb_ram_bus_master;
    localparam int W0 = 2;
    localparam int W1 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    ram_bus_master_if #(.DATA_WIDTH(8),  .RAM_DEPTH(256)) bus0 ();
    ram_bus_master_if #(.DATA_WIDTH(16), .RAM_DEPTH(200)) bus1 ();
    wire [7:0]  data0;
    wire [15:0] data1;

    ram_bus_master #(.DATA_WIDTH(8), .RAM_DEPTH(256), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .data(data0));
    ram_bus_master #(.DATA_WIDTH(16), .RAM_DEPTH(200), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .data(data1));

    // RAM models: drive data only for read transactions, store on clock while write is high.
    logic [7:0]  ram0 [256];
    logic [15:0] ram1 [256];
    logic        rd_op0 = 1'b0;
    logic        rd_op1 = 1'b0;
    assign data0 = (bus0.chip_select && !bus0.write && rd_op0) ? ram0[bus0.address] : 8'bz;
    assign data1 = (bus1.chip_select && !bus1.write && rd_op1) ? ram1[bus1.address] : 16'bz;
    always @(posedge clk) if (bus0.chip_select && bus0.write) ram0[bus0.address] <= data0;
    always @(posedge clk) if (bus1.chip_select && bus1.write) ram1[bus1.address] <= data1;

    // Reference memory contents and expected read responses.
    logic [15:0] ref0 [256];
    logic [15:0] ref1 [256];
    typedef struct { logic [15:0] d; int cyc; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus0.req = r; bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d[7:0];
        end else begin
            bus1.req = r; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.ready : bus1.ready;
    endfunction

    // Presents a request and leaves req high; returns the cycle number of the accepting edge.
    task automatic issue(input int sel, input logic w, input logic [7:0] a,
                         input logic [15:0] d, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        while (!rdy(sel) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", guard < 40, 1'b1);
        if (sel == 0) rd_op0 = !w; else rd_op1 = !w;
        @(posedge clk);
        #1;
        acc = cyc;
        if (sel == 0) begin
            if (w) ref0[a] = {8'h00, d[7:0]};
            else   q0.push_back('{ref0[a], acc + W0 + 1});
        end else begin
            if (w) ref1[a] = d;
            else   q1.push_back('{ref1[a], acc + W1 + 1});
        end
    endtask

    // Toggles req and request fields randomly until the master is idle again, then drops req.
    task automatic busy_noise(input int sel);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy(sel) && guard < 40) begin
            drive(sel, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
            @(negedge clk);
            guard++;
        end
        check("noise_timeout", guard < 40, 1'b1);
        drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.rd_valid) begin
                check("rd0_expected", q0.size() > 0, 1'b1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    check("rd0_data", bus0.rd_data, e0.d[7:0]);
                    check("rd0_cycle", cyc, e0.cyc);
                end
            end
            if (bus1.rd_valid) begin
                check("rd1_expected", q1.size() > 0, 1'b1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("rd1_data", bus1.rd_data, e1.d);
                    check("rd1_cycle", cyc, e1.cyc);
                end
            end
            if (bus0.write) check("wr0_needs_cs", bus0.chip_select, 1'b1);
            if (bus1.write) check("wr1_needs_cs", bus1.chip_select, 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a, acc_b, sel, mode;
        logic       w;
        logic [7:0] a;
        logic [15:0] d;

        for (int i = 0; i < 256; i++) begin
            ram0[i] = 8'($urandom);
            ram1[i] = 16'($urandom);
            ref0[i] = {8'h00, ram0[i]};
            ref1[i] = ram1[i];
        end
        ram0[0] = 8'h11;
        ref0[0] = 16'h0011;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);

        repeat (2) @(negedge clk);
        check("rst_ready",    bus0.ready, 1'b1);
        check("rst_rd_valid", bus0.rd_valid, 1'b0);
        check("rst_rd_data",  bus0.rd_data, 8'h00);
        check("rst_address",  bus0.address, 8'h00);
        check("rst_cs",       bus0.chip_select, 1'b0);
        check("rst_write",    bus0.write, 1'b0);
        reset = 1'b0;

        // Write 0xA5 to 0x3C with phase-by-phase strobe checks.
        issue(0, 1'b1, 8'h3C, 16'h00A5, acc_a);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("setup_cs",   bus0.chip_select, 1'b1);
        check("setup_we",   bus0.write, 1'b0);
        check("setup_addr", bus0.address, 8'h3C);
        check("busy_ready", bus0.ready, 1'b0);
        @(negedge clk);
        check("acc1_we",   bus0.write, 1'b1);
        check("acc1_data", data0, 8'hA5);
        @(negedge clk);
        check("acc2_we",   bus0.write, 1'b1);
        @(negedge clk);
        check("rec_cs",    bus0.chip_select, 1'b0);
        check("rec_we",    bus0.write, 1'b0);
        check("rec_data",  data0, 8'hA5);
        check("rec_ready", bus0.ready, 1'b0);
        @(negedge clk);
        check("idle_ready", bus0.ready, 1'b1);
        check("ram_3c",     ram0[8'h3C], 8'hA5);

        issue(0, 1'b0, 8'h3C, 16'h0000, acc_a);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (5) @(negedge clk);
        check("rd_hold", bus0.rd_data, 8'hA5);

        // Boundary addresses back to back with req held, then busy noise.
        issue(0, 1'b1, 8'hFF, 16'h00FF, acc_a);
        issue(0, 1'b0, 8'h00, 16'h0000, acc_b);
        check("b2b_spacing0", acc_b - acc_a, W0 + 3);
        busy_noise(0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a read access.
        issue(0, 1'b0, 8'h10, 16'h0000, acc_a);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cs",      bus0.chip_select, 1'b0);
        check("mid_rst_we",      bus0.write, 1'b0);
        check("mid_rst_ready",   bus0.ready, 1'b1);
        check("mid_rst_rdvalid", bus0.rd_valid, 1'b0);
        check("mid_rst_rd_data", bus0.rd_data, 8'h00);
        check("mid_rst_addr",    bus0.address, 8'h00);
        q0.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_rd_data", bus0.rd_data, 8'h00);
        issue(0, 1'b0, 8'hFF, 16'h0000, acc_a);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (5) @(negedge clk);

        // Wide/short-wait master: 0xBEEF at the last word, write then read back to back.
        issue(1, 1'b1, 8'd199, 16'hBEEF, acc_a);
        issue(1, 1'b0, 8'd199, 16'h0000, acc_b);
        check("b2b_spacing1", acc_b - acc_a, W1 + 3);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (5) @(negedge clk);

        // Randomized mix on both masters.
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 1));
            w   = 1'($urandom);
            a   = (sel == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 199));
            d   = (sel == 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
            if (n % 10 == 0) a = (sel == 0) ? 8'hFF : 8'd199;
            issue(sel, w, a, d, acc_a);
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                busy_noise(sel);
            end else if (mode == 1) begin
                @(negedge clk);
                drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end else begin
                a = (sel == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 199));
                issue(sel, 1'($urandom), a, (sel == 0) ? {8'h00, 8'($urandom)} : 16'($urandom), acc_b);
                check("rand_b2b", acc_b - acc_a, ((sel == 0) ? W0 : W1) + 3);
                @(negedge clk);
                drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000);
            end
        end

        repeat (10) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        for (int i = 0; i < 256; i++) check("ram0_final", ram0[i], ref0[i][7:0]);
        for (int i = 0; i < 200; i++) check("ram1_final", ram1[i], ref1[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
